aer_transmitter: RTL and testbench

Sender side of the DVS four-phase AER handshake. Events enter over a valid/ready stream, are buffered in a small FIFO, and are driven onto a 10-bit `aer` bus with `xsel` and `req`. The block then waits for a `ack` from the receiver, which it double-flop synchronises before use. It serves as a DVS camera emulator for board loopback testing, and as the outbound AER port wherever the design has to source events rather than sink them.

---
 rtl/aer_pkg.sv | 19 +
 rtl/aer_event_fifo.sv | 63 ++++++
 rtl/aer_transmitter.sv | 145 ++++++++++++++
 tb/tb_aer_transmitter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared types for the AER transmitter: handshake state encoding and the
// buffered event record.
package aer_pkg;

    localparam int AER_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        ACK_LO
    } aer_tx_state_t;

    typedef struct packed {
        logic                  xsel;
        logic [AER_ADDR_W-1:0] addr;
    } aer_event_t;

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous event FIFO with show-ahead read data. Pushes into a full FIFO
// and pops from an empty one are ignored.
module aer_event_fifo
    import aer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  aer_event_t       push_data,
    input  logic             pop,
    output aer_event_t       pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    aer_event_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; the count and pointers define which entries
    // are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/aer_transmitter.sv
// Sender side of the four-phase AER handshake: buffers stream events and
// drives them onto aer/xsel/req, pacing each transfer by the receiver's ack.
module aer_transmitter
    import aer_pkg::*;
#(
    parameter int ADDR_W         = AER_ADDR_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_xsel,
    output logic [ADDR_W-1:0] aer,
    output logic              xsel,
    output logic              req,
    input  logic              ack,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  =
        (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    aer_tx_state_t    state;
    aer_tx_state_t    state_nxt;
    logic             ack_mid;
    logic             ack_s;
    aer_event_t       fifo_in;
    aer_event_t       fifo_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [SET_W-1:0] setup_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             to_hit;
    logic             load_event;
    logic             req_nxt;
    logic             set_err;

    assign fifo_in.xsel = in_xsel;
    assign fifo_in.addr = in_addr;

    aer_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (fifo_in),
        .pop       (load_event),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign to_hit   = TO_EN && (to_cnt == TO_LAST);

    // ack comes from another clock domain; only the second flop is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_mid <= 1'b0;
            ack_s   <= 1'b0;
        end else begin
            ack_mid <= ack;
            ack_s   <= ack_mid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty && !ack_s) state_nxt = SETUP;
            SETUP:   if (setup_cnt == '0)       state_nxt = REQ_HI;
            REQ_HI:  if (ack_s || to_hit)       state_nxt = ACK_LO;
            ACK_LO:  if (!ack_s || to_hit)      state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // An ack edge arriving in the same cycle as the limit is a normal completion.
    always_comb begin
        load_event = (state == IDLE) && (state_nxt == SETUP);
        req_nxt    = (state_nxt == REQ_HI);
        set_err    = to_hit && (((state == REQ_HI) && !ack_s) ||
                                ((state == ACK_LO) &&  ack_s));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aer         <= '0;
            xsel        <= 1'b0;
            req         <= 1'b0;
            setup_cnt   <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            req <= req_nxt;
            if (load_event) begin
                aer  <= fifo_out.addr;
                xsel <= fifo_out.xsel;
            end
            if (load_event) begin
                setup_cnt <= SET_LAST;
            end else if (setup_cnt != '0) begin
                setup_cnt <= setup_cnt - 1'b1;
            end
            // The wait counter restarts on every state change, covering both
            // entry into REQ_HI and entry into ACK_LO.
            if (state_nxt != state) begin
                to_cnt <= '0;
            end else if (!to_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (set_err) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aer_transmitter.sv
// Self-checking bench for aer_transmitter: cycle table for one handshake,
// directed corner sequences, and a randomised receiver against a scoreboard.
module tb_aer_transmitter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_addr;
    logic       in_xsel;
    logic [9:0] aer;
    logic       xsel;
    logic       req;
    logic       ack;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;

    logic       t_in_valid;
    logic       t_in_ready;
    logic [9:0] t_in_addr;
    logic       t_in_xsel;
    logic [9:0] t_aer;
    logic       t_xsel;
    logic       t_req;
    logic       t_ack;
    logic       t_busy;
    logic       t_timeout_err;
    logic       t_err_clr;

    int n_checks = 0;
    int n_errors = 0;
    int seen     = 0;

    logic [10:0] exp_q[$];
    logic        req_prev = 1'b0;
    logic        ack_d1   = 1'b0;
    logic        ack_d2   = 1'b0;

    aer_transmitter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_xsel     (in_xsel),
        .aer         (aer),
        .xsel        (xsel),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    aer_transmitter #(
        .TIMEOUT_CYCLES (16)
    ) dut_to (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (t_in_valid),
        .in_ready    (t_in_ready),
        .in_addr     (t_in_addr),
        .in_xsel     (t_in_xsel),
        .aer         (t_aer),
        .xsel        (t_xsel),
        .req         (t_req),
        .ack         (t_ack),
        .busy        (t_busy),
        .timeout_err (t_timeout_err),
        .err_clr     (t_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted push is expected on the bus, once, in order.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back({in_xsel, in_addr});
        end
        ack_d1 <= ack;
        ack_d2 <= ack_d1;
    end

    always @(negedge rst_n) begin
        exp_q.delete();
    end

    always @(negedge clk) begin
        if (rst_n && req && !req_prev) begin
            check("pending_at_req", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("event_order", {21'd0, xsel, aer}, {21'd0, exp_q.pop_front()});
                seen++;
            end
            check("ack_s_low_at_req", 32'(ack_d2), 32'd0);
        end
        req_prev = req;
    end

    task automatic push_ev(input logic [9:0] a, input logic x);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_xsel  = x;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic respond(input int lat);
        int n;
        n = 0;
        while (!req && n < 300) begin
            tick();
            n++;
        end
        check("req_rise", 32'(req), 32'd1);
        repeat (lat) tick();
        ack = 1'b1;
        n = 0;
        while (req && n < 300) begin
            tick();
            n++;
        end
        check("req_fall", 32'(req), 32'd0);
        ack = 1'b0;
    endtask

    typedef struct {
        logic       vld;
        logic [9:0] addr;
        logic       xs;
        logic       ack_in;
        logic       exp_req;
        logic [9:0] exp_aer;
        logic       exp_xsel;
        logic       exp_busy;
        logic       exp_rdy;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int base;

        // Single event with a responsive receiver, one row per clock edge.
        vecs[0] = '{1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b0, 1'b1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_xsel    = 1'b0;
        ack        = 1'b0;
        err_clr    = 1'b0;
        t_in_valid = 1'b0;
        t_in_addr  = '0;
        t_in_xsel  = 1'b0;
        t_ack      = 1'b0;
        t_err_clr  = 1'b0;

        #12;
        check("rst_req",      32'(req), 32'd0);
        check("rst_aer",      32'(aer), 32'd0);
        check("rst_xsel",     32'(xsel), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err",      32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].vld;
            in_addr  = vecs[i].addr;
            in_xsel  = vecs[i].xs;
            ack      = vecs[i].ack_in;
            tick();
            check($sformatf("vec%0d", i),
                  {19'd0, req, aer, xsel, busy, in_ready},
                  {19'd0, vecs[i].exp_req, vecs[i].exp_aer, vecs[i].exp_xsel,
                   vecs[i].exp_busy, vecs[i].exp_rdy});
        end

        // Stale ack: an event waits in IDLE until ack is seen low.
        ack = 1'b1;
        repeat (3) tick();
        push_ev(10'h2AA, 1'b0);
        repeat (4) tick();
        check("stale_aer",  32'(aer), 32'h155);
        check("stale_req",  32'(req), 32'd0);
        check("stale_busy", 32'(busy), 32'd1);
        ack = 1'b0;
        tick();
        tick();
        check("stale_aer_b1", 32'(aer), 32'h155);
        tick();
        check("stale_pop", {21'd0, xsel, aer}, {21'd0, 1'b0, 10'h2AA});
        respond(0);

        // FIFO full: four stored plus one in flight, sixth push stalls.
        ack  = 1'b0;
        base = seen;
        for (int i = 0; i < 5; i++) begin
            push_ev(10'(10'h040 + i), 1'(i));
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_addr  = 10'h3C3;
        in_xsel  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("full_stall%0d", i), 32'(in_ready), 32'd0);
        end
        check("full_pending", 32'(exp_q.size()), 32'd4);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) respond(0);
        check("full_drained", 32'(seen - base), 32'd5);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // Timeout on the 16-cycle instance with ack stuck low.
        check("to_in_ready", 32'(t_in_ready), 32'd1);
        t_in_valid = 1'b1;
        t_in_addr  = 10'h3FF;
        t_in_xsel  = 1'b1;
        tick();
        t_in_valid = 1'b0;
        n = 0;
        while (!t_req && n < 20) begin
            tick();
            n++;
        end
        check("to_req_rise", 32'(t_req), 32'd1);
        check("to_bus", {21'd0, t_xsel, t_aer}, {21'd0, 1'b1, 10'h3FF});
        n = 0;
        while (t_req && n < 100) begin
            tick();
            n++;
        end
        check("to_req_high_cycles", 32'(n), 32'd16);
        check("to_err_set", 32'(t_timeout_err), 32'd1);
        repeat (3) tick();
        check("to_err_sticky", 32'(t_timeout_err), 32'd1);
        check("to_idle", 32'(t_busy), 32'd0);
        t_err_clr = 1'b1;
        tick();
        t_err_clr = 1'b0;
        check("to_err_clr", 32'(t_timeout_err), 32'd0);

        // Reset in the middle of REQ_HI with events still buffered.
        push_ev(10'h0A1, 1'b1);
        push_ev(10'h0B2, 1'b0);
        push_ev(10'h0C3, 1'b1);
        n = 0;
        while (!req && n < 50) begin
            tick();
            n++;
        end
        check("mid_req_seen", 32'(req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",      32'(req), 32'd0);
        check("mid_rst_aer",      32'(aer), 32'd0);
        check("mid_rst_xsel",     32'(xsel), 32'd0);
        check("mid_rst_busy",     32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_req",  32'(req), 32'd0);

        // Randomised receiver latency against the scoreboard.
        base = seen;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push_ev(10'($urandom), 1'($urandom));
                end
            end
            begin
                for (int i = 0; i < 200; i++) respond(int'($urandom_range(0, 20)));
            end
        join
        repeat (5) tick();
        check("rand_seen", 32'(seen - base), 32'd200);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_idle", 32'(busy), 32'd0);
        check("rand_no_err", 32'(timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
